// File: rtl/awb_stats_gain.sv
// Auto white-balance statistics and gray-world gain engine.
// Accumulates per-frame R/G/B sums from the Bayer quad stream (skipping quads
// with near-saturated pixels) and, at frame end, derives R and B gains with a
// shared restoring divider. Gains are held until the next update.
module awb_stats_gain #(
  parameter int DW_IN   = 10,
  parameter int DW_GAIN = 10,
  parameter int DW_DEC  = 8,
  parameter int DW_ACC  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           CFA,
  input  logic                 awb_en,
  input  logic                 vsync_in,
  input  logic                 hsync_in,
  input  logic [DW_IN*4-1:0]   data_in,
  input  logic [DW_IN-1:0]     sat_thr,
  output logic [DW_GAIN-1:0]   R_gain,
  output logic [DW_GAIN-1:0]   G_gain,
  output logic [DW_GAIN-1:0]   B_gain,
  output logic                 gain_valid,
  output logic                 busy
);

  localparam int QW = DW_ACC + DW_DEC;
  localparam int CW = $clog2(QW + 1);
  localparam logic [DW_GAIN-1:0] GAIN_ONE = DW_GAIN'(2 ** DW_DEC);

  typedef enum logic [2:0] {IDLE, LATCH, DIV_R, DIV_B, UPDATE} state_t;

  state_t state, state_nx;

  logic [DW_IN-1:0]  p11, p12, p21, p22;
  logic [DW_IN-1:0]  r_pix, b_pix;
  logic [DW_IN:0]    g_pix;
  logic              excl, sample, frame_start, frame_end, vsync_d;
  logic [DW_ACC-1:0] r_sum, g_sum, b_sum;
  logic [DW_ACC-1:0] r_base, g_base, b_base;
  logic [DW_ACC-1:0] r_sum_nx, g_sum_nx, b_sum_nx;
  logic [DW_ACC-1:0] r_lat, g_lat, b_lat;
  logic [CW-1:0]     cnt;
  logic              cnt_last;
  logic [DW_ACC:0]   d_reg;
  logic [QW-1:0]     nsh, quo, q_nx;
  logic [QW:0]       rem, trial, d_ext, rem_nx;
  logic              qbit;
  logic [DW_GAIN-1:0] r_res, b_res;

  // Sum that sticks at all-ones instead of wrapping.
  function automatic logic [DW_ACC-1:0] sat_add(input logic [DW_ACC-1:0] a,
                                                input logic [DW_ACC-1:0] b);
    logic [DW_ACC:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW_ACC] ? {DW_ACC{1'b1}} : s[DW_ACC-1:0];
  endfunction

  // Clamp the quotient to the gain range; divide-by-zero maps to max gain.
  function automatic logic [DW_GAIN-1:0] sat_gain(input logic [QW-1:0] q,
                                                  input logic d_zero);
    if (d_zero || (|q[QW-1:DW_GAIN]))
      return {DW_GAIN{1'b1}};
    return q[DW_GAIN-1:0];
  endfunction

  assign p11 = data_in[4*DW_IN-1 -: DW_IN];
  assign p12 = data_in[3*DW_IN-1 -: DW_IN];
  assign p21 = data_in[2*DW_IN-1 -: DW_IN];
  assign p22 = data_in[DW_IN-1 -: DW_IN];

  // Route quad lanes to colour channels according to the Bayer phase.
  always_comb begin
    r_pix = p12;
    b_pix = p21;
    g_pix = {1'b0, p11} + {1'b0, p22};
    case (CFA)
      2'b01: begin
        r_pix = p11;
        b_pix = p22;
        g_pix = {1'b0, p12} + {1'b0, p21};
      end
      2'b10: begin
        r_pix = p22;
        b_pix = p11;
        g_pix = {1'b0, p12} + {1'b0, p21};
      end
      2'b11: begin
        r_pix = p21;
        b_pix = p12;
        g_pix = {1'b0, p11} + {1'b0, p22};
      end
      default: ;
    endcase
  end

  assign excl        = (p11 >= sat_thr) || (p12 >= sat_thr) ||
                       (p21 >= sat_thr) || (p22 >= sat_thr);
  assign sample      = vsync_in && hsync_in && !excl;
  assign frame_start = vsync_in && !vsync_d;
  assign frame_end   = vsync_d && !vsync_in;

  // Next sums: clear on frame start, then fold in the current quad if kept.
  always_comb begin
    r_base   = frame_start ? '0 : r_sum;
    g_base   = frame_start ? '0 : g_sum;
    b_base   = frame_start ? '0 : b_sum;
    r_sum_nx = sample ? sat_add(r_base, DW_ACC'(r_pix)) : r_base;
    g_sum_nx = sample ? sat_add(g_base, DW_ACC'(g_pix)) : g_base;
    b_sum_nx = sample ? sat_add(b_base, DW_ACC'(b_pix)) : b_base;
  end

  // ---- stage: frame statistics accumulation ----
  // Register vsync edge detector and per-channel sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      r_sum   <= '0;
      g_sum   <= '0;
      b_sum   <= '0;
    end else begin
      vsync_d <= vsync_in;
      r_sum   <= r_sum_nx;
      g_sum   <= g_sum_nx;
      b_sum   <= b_sum_nx;
    end
  end

  // Snapshot the sums on a qualifying frame end so the next frame can run.
  always_ff @(posedge clk) begin
    if (state == IDLE && frame_end && awb_en) begin
      r_lat <= r_sum;
      g_lat <= g_sum;
      b_lat <= b_sum;
    end
  end

  // ---- stage: gain computation control ----
  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign cnt_last = (cnt == CW'(QW - 1));

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_end && awb_en) state_nx = LATCH;
      LATCH:   state_nx = DIV_R;
      DIV_R:   if (cnt_last) state_nx = DIV_B;
      DIV_B:   if (cnt_last) state_nx = UPDATE;
      UPDATE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Quotient-bit counter, restarted for each of the two divisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == DIV_R || state == DIV_B)
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    else
      cnt <= '0;
  end

  // One restoring-division step: bring down the next numerator bit.
  always_comb begin
    trial  = {rem[QW-1:0], nsh[QW-1]};
    d_ext  = {{(QW-DW_ACC){1'b0}}, d_reg};
    qbit   = (trial >= d_ext);
    rem_nx = qbit ? (trial - d_ext) : trial;
    q_nx   = {quo[QW-2:0], qbit};
  end

  // ---- stage: sequential divider ----
  // Divider datapath: R division first, then reloaded for B.
  always_ff @(posedge clk) begin
    case (state)
      LATCH: begin
        nsh   <= {g_lat, {DW_DEC{1'b0}}};
        d_reg <= {r_lat, 1'b0};
        rem   <= '0;
        quo   <= '0;
      end
      DIV_R: begin
        if (cnt_last) begin
          r_res <= sat_gain(q_nx, d_reg == '0);
          nsh   <= {g_lat, {DW_DEC{1'b0}}};
          d_reg <= {b_lat, 1'b0};
          rem   <= '0;
          quo   <= '0;
        end else begin
          nsh <= {nsh[QW-2:0], 1'b0};
          rem <= rem_nx;
          quo <= q_nx;
        end
      end
      DIV_B: begin
        if (cnt_last) begin
          b_res <= sat_gain(q_nx, d_reg == '0);
        end else begin
          nsh <= {nsh[QW-2:0], 1'b0};
          rem <= rem_nx;
          quo <= q_nx;
        end
      end
      default: ;
    endcase
  end

  // ---- stage: gain outputs ----
  // Publish both gains together with a one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_gain     <= GAIN_ONE;
      B_gain     <= GAIN_ONE;
      gain_valid <= 1'b0;
    end else begin
      gain_valid <= (state == UPDATE);
      if (state == UPDATE) begin
        R_gain <= r_res;
        B_gain <= b_res;
      end
    end
  end

  assign G_gain = GAIN_ONE;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_awb_stats_gain.sv
// Directed bench for awb_stats_gain: drives whole frames of quads and checks
// the resulting gains, pulse latency, busy behaviour and async reset.
module tb_awb_stats_gain;

  logic        clk;
  logic        rst_n;
  logic [1:0]  CFA;
  logic        awb_en;
  logic        vsync_in;
  logic        hsync_in;
  logic [39:0] data_in;
  logic [9:0]  sat_thr;
  logic [9:0]  R_gain, G_gain, B_gain;
  logic        gain_valid;
  logic        busy;

  int n_chk;
  int n_fail;

  awb_stats_gain dut (
    .clk(clk), .rst_n(rst_n), .CFA(CFA), .awb_en(awb_en),
    .vsync_in(vsync_in), .hsync_in(hsync_in), .data_in(data_in),
    .sat_thr(sat_thr), .R_gain(R_gain), .G_gain(G_gain), .B_gain(B_gain),
    .gain_valid(gain_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mkq(input logic [1:0] c, input logic [9:0] r,
                                      input logic [9:0] g1, input logic [9:0] g2,
                                      input logic [9:0] b);
    case (c)
      2'b00:   return {g1, r, b, g2};
      2'b01:   return {r, g1, g2, b};
      2'b10:   return {b, g1, g2, r};
      default: return {g1, b, r, g2};
    endcase
  endfunction

  // n quads, alternating qa/qb; returns at the negedge inside cycle T.
  task automatic run_frame(input logic [1:0] c, input logic [39:0] qa,
                           input logic [39:0] qb, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      CFA      = c;
      vsync_in = 1'b1;
      hsync_in = 1'b1;
      data_in  = (i % 2 == 1) ? qb : qa;
    end
    @(negedge clk);
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    data_in  = '0;
  endtask

  // Watch budget cycles after T: first pulse offset, pulse count, busy info.
  task automatic watch(input int budget, output int lat, output int pulses,
                       output int busy1, output int busy_any);
    lat = -1; pulses = 0; busy1 = 0; busy_any = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = int'(busy);
      if (busy) busy_any = 1;
      if (gain_valid) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  int lat, pulses, busy1, busy_any;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; CFA = 2'b00; awb_en = 1'b1; vsync_in = 1'b0;
    hsync_in = 1'b0; data_in = '0; sat_thr = 10'd1023;
    repeat (3) @(negedge clk);
    check("rst_R_gain", int'(R_gain), 256);
    check("rst_G_gain", int'(G_gain), 256);
    check("rst_B_gain", int'(B_gain), 256);
    check("rst_gain_valid", int'(gain_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // CFA=01 basic frame and latency
    run_frame(2'b01, mkq(2'b01, 100, 200, 200, 80), mkq(2'b01, 100, 200, 200, 80), 16);
    check("t1_busy_at_T", int'(busy), 0);
    watch(120, lat, pulses, busy1, busy_any);
    check("t1_busy_latch", busy1, 1);
    check("t1_latency", lat, 83);
    check("t1_pulses", pulses, 1);
    check("t1_R_gain", int'(R_gain), 512);
    check("t1_B_gain", int'(B_gain), 640);
    check("t1_G_gain", int'(G_gain), 256);
    check("t1_busy_end", int'(busy), 0);

    // CFA=11 lane mapping
    run_frame(2'b11, mkq(2'b11, 2, 3, 3, 3), mkq(2'b11, 2, 3, 3, 3), 8);
    watch(100, lat, pulses, busy1, busy_any);
    check("t2_R_gain", int'(R_gain), 384);
    check("t2_B_gain", int'(B_gain), 256);

    // R=0: divide by zero saturates
    run_frame(2'b00, mkq(2'b00, 0, 100, 100, 100), mkq(2'b00, 0, 100, 100, 100), 6);
    watch(100, lat, pulses, busy1, busy_any);
    check("t3_R_gain_d0", int'(R_gain), 1023);
    check("t3_B_gain", int'(B_gain), 256);

    // Large G, tiny R: quotient overflow saturates
    run_frame(2'b10, mkq(2'b10, 1, 1000, 1000, 1000), mkq(2'b10, 1, 1000, 1000, 1000), 4);
    watch(100, lat, pulses, busy1, busy_any);
    check("t4_R_gain_ovf", int'(R_gain), 1023);
    check("t4_B_gain", int'(B_gain), 256);

    // Saturated quads excluded
    sat_thr = 10'd900;
    run_frame(2'b01, mkq(2'b01, 1000, 500, 500, 500), mkq(2'b01, 100, 200, 200, 100), 10);
    watch(100, lat, pulses, busy1, busy_any);
    check("t5_R_gain", int'(R_gain), 512);
    check("t5_B_gain", int'(B_gain), 512);
    sat_thr = 10'd1023;

    // awb_en=0 at frame end: nothing happens
    awb_en = 1'b0;
    run_frame(2'b01, mkq(2'b01, 50, 100, 100, 25), mkq(2'b01, 50, 100, 100, 25), 4);
    watch(100, lat, pulses, busy1, busy_any);
    check("t6_busy_any", busy_any, 0);
    check("t6_pulses", pulses, 0);
    check("t6_R_hold", int'(R_gain), 512);
    check("t6_B_hold", int'(B_gain), 512);
    awb_en = 1'b1;

    // Second frame end while busy is ignored
    run_frame(2'b01, mkq(2'b01, 100, 200, 200, 80), mkq(2'b01, 100, 200, 200, 80), 16);
    run_frame(2'b01, mkq(2'b01, 200, 200, 200, 200), mkq(2'b01, 200, 200, 200, 200), 3);
    watch(200, lat, pulses, busy1, busy_any);
    check("t7_pulses", pulses, 1);
    check("t7_R_gain", int'(R_gain), 512);
    check("t7_B_gain", int'(B_gain), 640);

    // Async reset during DIV_B
    run_frame(2'b01, mkq(2'b01, 100, 200, 200, 100), mkq(2'b01, 100, 200, 200, 100), 8);
    repeat (50) @(negedge clk);
    check("t8_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t8_R_async", int'(R_gain), 256);
    check("t8_B_async", int'(B_gain), 256);
    check("t8_busy_async", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(100, lat, pulses, busy1, busy_any);
    check("t8_no_pulse", pulses, 0);
    check("t8_R_hold", int'(R_gain), 256);
    run_frame(2'b01, mkq(2'b01, 100, 200, 200, 64), mkq(2'b01, 100, 200, 200, 64), 8);
    watch(100, lat, pulses, busy1, busy_any);
    check("t8_latency", lat, 83);
    check("t8_R_gain", int'(R_gain), 512);
    check("t8_B_gain", int'(B_gain), 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/awb_stats_gain.md
# awb_stats_gain

Automatic white-balance statistics and gain engine for the Bayer path. It taps the same 2x2-quad stream that feeds `wb_gain` and accumulates per-frame R, G and B sums, excluding quads that contain near-saturated pixels. At each frame end it computes gray-world gains with a sequential divider. The resulting `R_gain`/`G_gain`/`B_gain` drive `wb_gain` directly and are held stable for the whole next frame.

## Interface
Parameters:
- DW_IN, 10, pixel width
- DW_GAIN, 10, gain width (unsigned, DW_DEC fractional bits)
- DW_DEC, 8, gain fractional bits
- DW_ACC, 32, accumulator width per channel

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- CFA  input  2  Bayer phase of the quad, same encoding as `wb_gain`
- awb_en  input  1  enables gain update at frame end
- vsync_in  input  1  high during active frame
- hsync_in  input  1  high while `data_in` carries a valid quad
- data_in  input  DW_IN*4  quad {p11,p12,p21,p22}, MSB first
- sat_thr  input  DW_IN  saturation exclusion threshold
- R_gain  output  DW_GAIN  red gain
- G_gain  output  DW_GAIN  green gain
- B_gain  output  DW_GAIN  blue gain
- gain_valid  output  1  one-cycle pulse when the gains update
- busy  output  1  high while the divider runs

## Operation
- CFA mapping of {p11,p12,p21,p22}: 00={G,R,B,G}, 01={R,G,G,B}, 10={B,G,G,R}, 11={G,B,R,G}.
- Quad sampling: a quad is sampled when vsync_in && hsync_in. It is excluded if any pixel >= sat_thr.
- Accumulation per sampled quad: Rsum += R, Bsum += B, Gsum += G1+G2. Each sum saturates at all-ones and never wraps.
- Frame start (vsync_in rising, i.e. registered vsync_d=0, vsync_in=1): all three sums clear to 0 on that cycle. The quad present on that cycle is accumulated into the cleared sums.
- Frame end (vsync_d=1, vsync_in=0), with FSM in IDLE and awb_en=1: latch Rsum, Gsum, Bsum and leave IDLE. Frame ends that occur while busy, or with awb_en=0, are ignored.
- FSM states:
  - IDLE → LATCH on a qualifying frame end.
  - LATCH (1 cycle): load the divider with N = Gsum<<DW_DEC and D = Rsum<<1.
  - DIV_R (QW = DW_ACC+DW_DEC cycles): restoring division, one quotient bit per cycle, MSB first.
  - DIV_B (QW cycles): same, with D = Bsum<<1; the R result is held.
  - UPDATE (1 cycle) → IDLE.
- Result rule: result = floor(N/D). If D==0 or result > 2^DW_GAIN−1, the result is 2^DW_GAIN−1.
- G_gain is always 1<<DW_DEC.
- The divider works on latched copies, so a new frame starting during DIV_R/DIV_B accumulates normally and is unaffected.

## Timing
- Reset values: R_gain=G_gain=B_gain=1<<DW_DEC (256 with defaults); gain_valid=0; busy=0; FSM in IDLE; sums=0.
- Let T be the first cycle on which vsync_in is sampled low after being high.
  - LATCH occupies T+1.
  - DIV_R occupies T+2 .. T+1+QW.
  - DIV_B occupies the next QW cycles.
  - UPDATE occupies T+2+2·QW.
- Outputs: R_gain/B_gain change and gain_valid=1 on the clock edge that ends UPDATE, i.e. visible at T+3+2·QW. With the defaults this is T+83.
- busy is high from LATCH through UPDATE inclusive.
- Gains change only at that edge. Between updates they are stable.
- Reset asserted mid-division: everything returns to reset values immediately (asynchronously), and no gain_valid pulse occurs.
- Sums are registered; accumulate latency is 1 cycle. The quad sampled on the cycle before T is included in the frame.

## Test plan
All scenarios use default parameters and sat_thr=1023.
- CFA=01, one frame of 16 quads with R=100, G=200/200, B=80 → R_gain=512, B_gain=640, G_gain=256, gain_valid pulse exactly at T+83.
- CFA=11, frame of quads with R=2, G=3/3, B=3 → R_gain=384, B_gain=256. Confirms lane mapping.
- R=0 in all quads, G=100, B=100 → R_gain=1023 (D=0 saturation), B_gain=256. Also G=1000, R=1 → R_gain=1023 (overflow saturation).
- sat_thr=900, half the quads {R=1000,G=500,B=500} and half {R=100,G=200,B=100} → only the second set counts, giving R_gain=512, B_gain=512.
- awb_en=0 at frame end → no busy and no gain_valid; gains hold their previous values. Second frame end while busy → ignored, exactly one gain_valid pulse.
- rst_n low for 1 cycle during DIV_B → gains return to 256 asynchronously, busy=0, no gain_valid. The next full frame computes correctly.
